// File: rtl/print_uart_tx.sv
// Print-channel consumer: buffers 32-bit words from data memory in a FIFO and
// sends each one over UART 8N1, least-significant byte first.
module print_uart_tx #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 8,
    parameter int SKIP_ZERO  = 1
) (
    input  logic                          clk,
    input  logic                          start,
    input  logic                          print_en,
    input  logic [31:0]                   print_data,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CPB = CLK_FREQ / BAUD_RATE;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam int BW  = $clog2(CPB);

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

    state_t                        state;
    logic [FIFO_DEPTH-1:0][31:0]   mem;
    logic [PW-1:0]                 wr_ptr, rd_ptr;
    logic [CW-1:0]                 count;
    logic                          full, empty, push, pop;
    logic [3:0][7:0]               shift_word;
    logic [1:0]                    byte_idx;
    logic [2:0]                    bit_idx;
    logic [7:0]                    shift;
    logic [BW-1:0]                 baud_cnt;
    logic                          baud_done;
    logic [7:0]                    cur_byte;

    // Fullness is judged on the pre-edge count, so a same-cycle pop never frees room.
    assign full       = (count == CW'(FIFO_DEPTH));
    assign empty      = (count == '0);
    assign push       = print_en && !full;
    assign pop        = (state == IDLE) && !empty;
    assign baud_done  = (baud_cnt == BW'(CPB - 1));
    assign cur_byte   = shift_word[byte_idx];
    assign fifo_count = count;
    assign busy       = (state != IDLE) || !empty;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= print_data;
    end

    always_ff @(posedge clk) begin
        if (!start) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (print_en && full) overflow <= 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // tx is written every cycle from the current state, so it trails the state by one edge.
    always_ff @(posedge clk) begin
        if (!start) begin
            state      <= IDLE;
            tx         <= 1'b1;
            shift_word <= '0;
            byte_idx   <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            baud_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (!empty) begin
                        shift_word <= mem[rd_ptr];
                        byte_idx   <= '0;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    tx <= 1'b1;
                    if ((SKIP_ZERO != 0) && (cur_byte == 8'h00)) begin
                        if (byte_idx == 2'd3) state <= IDLE;
                        else                  byte_idx <= byte_idx + 1'b1;
                    end else begin
                        shift    <= cur_byte;
                        baud_cnt <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    tx <= 1'b0;
                    if (baud_done) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    tx <= shift[0];
                    if (baud_done) begin
                        baud_cnt <= '0;
                        shift    <= shift >> 1;
                        if (bit_idx == 3'd7) state <= STOP;
                        else                 bit_idx <= bit_idx + 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (byte_idx == 2'd3) begin
                            state <= IDLE;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                            state    <= LOAD;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_print_uart_tx.sv
// Directed bench for print_uart_tx: a UART sampler decodes tx of the
// SKIP_ZERO instance; a second instance with SKIP_ZERO=0 covers full-word timing.
module tb_print_uart_tx;

    logic        clk = 1'b0;
    logic        start, print_en, print_en0;
    logic [31:0] print_data;
    logic        tx, busy, overflow;
    logic [2:0]  fifo_count;
    logic        tx0, busy0, overflow0;
    logic [3:0]  fifo_count0;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] rx_q[$];
    int         rx_t[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    print_uart_tx #(.CLK_FREQ(8), .BAUD_RATE(1), .FIFO_DEPTH(4), .SKIP_ZERO(1)) u_dut (
        .clk(clk), .start(start), .print_en(print_en), .print_data(print_data),
        .tx(tx), .busy(busy), .overflow(overflow), .fifo_count(fifo_count)
    );

    print_uart_tx #(.CLK_FREQ(8), .BAUD_RATE(1), .FIFO_DEPTH(8), .SKIP_ZERO(0)) u_dut0 (
        .clk(clk), .start(start), .print_en(print_en0), .print_data(print_data),
        .tx(tx0), .busy(busy0), .overflow(overflow0), .fifo_count(fifo_count0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, output int t);
        @(negedge clk);
        print_en   = 1'b1;
        print_data = d;
        @(negedge clk);
        t        = cyc;
        print_en = 1'b0;
    endtask

    task automatic wait_idle(input int limit, output int t);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (busy === 1'b0) break;
        end
        t = cyc;
        chk("idle_reached", 32'(busy), 32'd0);
    endtask

    // 8N1 sampler: samples mid-bit, 8 clocks per bit.
    initial begin : rx
        int t;
        logic [7:0] b;
        b = '0;
        forever begin
            @(negedge clk);
            if (start === 1'b1 && tx === 1'b0) begin
                t = cyc;
                repeat (4) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (8) @(negedge clk);
                    b[i] = tx;
                end
                repeat (8) @(negedge clk);
                chk("rx_stop_bit", 32'(tx), 32'd1);
                rx_q.push_back(b);
                rx_t.push_back(t);
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int t0, ti, lows, first;
        start = 1'b0; print_en = 1'b0; print_en0 = 1'b0; print_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx",        32'(tx),          32'd1);
        chk("rst_busy",      32'(busy),        32'd0);
        chk("rst_overflow",  32'(overflow),    32'd0);
        chk("rst_count",     32'(fifo_count),  32'd0);
        chk("rst_tx0",       32'(tx0),         32'd1);
        chk("rst_count0",    32'(fifo_count0), 32'd0);
        @(negedge clk);
        start = 1'b1;
        repeat (2) @(negedge clk);

        // single word, upper zero bytes skipped
        send(32'h0000_0A41, t0);
        wait_idle(400, ti);
        chk("single_busy_fall", 32'(ti - t0), 32'd165);
        chk("single_nbytes",    32'(rx_q.size()), 32'd2);
        chk("single_byte0",     32'(rx_q[0]), 32'h41);
        chk("single_byte1",     32'(rx_q[1]), 32'h0A);
        chk("single_latency",   32'(rx_t[0] - t0), 32'd3);
        chk("single_gap",       32'(rx_t[1] - t0), 32'd84);

        // all-zero word with skipping disabled: four full frames
        @(negedge clk);
        print_en0 = 1'b1; print_data = 32'h0;
        @(negedge clk);
        print_en0 = 1'b0; t0 = cyc;
        lows = 0; first = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tx0 === 1'b0) begin
                lows++;
                if (first < 0) first = cyc;
            end
            if (busy0 === 1'b0) break;
        end
        chk("full_first_low",  32'(first - t0), 32'd3);
        chk("full_low_cycles", 32'(lows),       32'd288);
        chk("full_idle_time",  32'(cyc - t0),   32'd325);
        chk("full_busy0",      32'(busy0),      32'd0);

        // push coinciding with pop at count 1
        rx_q.delete(); rx_t.delete();
        @(negedge clk);
        print_en = 1'b1; print_data = 32'h0000_3231;
        @(negedge clk);
        chk("pp_count_first", 32'(fifo_count), 32'd1);
        print_data = 32'h0000_3433;
        @(negedge clk);
        print_en = 1'b0;
        chk("pp_count_same", 32'(fifo_count), 32'd1);
        wait_idle(600, ti);
        chk("pp_nbytes", 32'(rx_q.size()), 32'd4);
        for (int j = 0; j < 4; j++) chk("pp_byte", 32'(rx_q[j]), 32'(8'h31 + j));

        // overflow: six consecutive strobes into a depth-4 FIFO
        rx_q.delete(); rx_t.delete();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 5) begin
                chk("ovf_count_full", 32'(fifo_count), 32'd4);
                chk("ovf_not_yet",    32'(overflow),   32'd0);
            end
            print_en   = 1'b1;
            print_data = (i == 5) ? 32'h5A5A_5A5A :
                         {8'(8'h44 + 4*i), 8'(8'h43 + 4*i), 8'(8'h42 + 4*i), 8'(8'h41 + 4*i)};
        end
        @(negedge clk);
        print_en = 1'b0;
        chk("ovf_set",       32'(overflow),   32'd1);
        chk("ovf_count_cap", 32'(fifo_count), 32'd4);
        wait_idle(2500, ti);
        chk("ovf_nbytes", 32'(rx_q.size()), 32'd20);
        for (int j = 0; j < 20; j++) chk("ovf_byte", 32'(rx_q[j]), 32'(8'h41 + j));
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // reset during DATA bit 3 with a second word queued
        send(32'h0000_0055, t0);
        send(32'h0000_0066, ti);
        while (cyc < t0 + 38) @(negedge clk);
        chk("abort_pre_tx",    32'(tx),         32'd0);
        chk("abort_pre_count", 32'(fifo_count), 32'd1);
        start = 1'b0;
        @(negedge clk);
        chk("abort_tx",       32'(tx),         32'd1);
        chk("abort_count",    32'(fifo_count), 32'd0);
        chk("abort_busy",     32'(busy),       32'd0);
        chk("abort_overflow", 32'(overflow),   32'd0);
        start = 1'b1;
        repeat (100) @(negedge clk);
        rx_q.delete(); rx_t.delete();
        send(32'h0000_0037, t0);
        wait_idle(300, ti);
        chk("post_nbytes",  32'(rx_q.size()), 32'd1);
        chk("post_byte",    32'(rx_q[0]), 32'h37);
        chk("post_latency", 32'(rx_t[0] - t0), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/print_uart_tx.md
Name: print_uart_tx

Overview:
- Consumer end of the data-memory print channel.
- Accepts the one-cycle `print_en`/`print_data` word strobes from the data memory, including the boot message and stores to the print address.
- Buffers the words in a small FIFO and serialises each word as UART 8N1 bytes on `tx`, least-significant byte first.
- Sits at the top level between the core's data memory and the board UART pin.

Parameters:
- CLK_FREQ, 100_000_000, core clock frequency in Hz.
- BAUD_RATE, 115_200, UART bit rate. CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (integer division, must be ≥ 2).
- FIFO_DEPTH, 8, number of 32-bit word entries. Must be a power of two, ≥ 2.
- SKIP_ZERO, 1, when 1 a byte equal to 0x00 is not transmitted. This allows packed strings shorter than 4 chars.

Ports:
- clk  in  1  core clock, rising-edge.
- start  in  1  synchronous active-low reset. Block held in reset while 0.
- print_en  in  1  one-cycle strobe: `print_data` valid.
- print_data  in  32  word to print.
- tx  out  1  UART serial output, idle high.
- busy  out  1  1 while FIFO non-empty or a word is in flight.
- overflow  out  1  sticky: a strobe was dropped because the FIFO was full.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (start=0, sampled on clk):
  - tx=1, busy=0, overflow=0, fifo_count=0.
  - FIFO pointers cleared; FSM goes to IDLE; baud counter, bit index and byte index cleared.
  - Reset mid-frame aborts the frame immediately: tx=1 after the next edge, no stop bit completion.
- FIFO push:
  - When print_en=1 and fifo_count<FIFO_DEPTH, print_data is written and count increments at the edge.
  - When print_en=1 and fifo_count==FIFO_DEPTH, the word is dropped and overflow<=1, held until reset.
  - Fullness uses the pre-edge count: a pop in the same cycle does not make room for a push when full.
  - A simultaneous push and pop when neither full nor empty leaves the count unchanged.
- FSM states: IDLE, LOAD, START, DATA, STOP.
  - IDLE: tx=1. If fifo_count>0, pop the head word into shift_word, byte_idx<=0, go to LOAD.
  - LOAD (1 cycle): byte = shift_word[8*byte_idx +: 8].
    - If SKIP_ZERO and byte==0: if byte_idx==3 go to IDLE, else byte_idx++ and stay in LOAD.
    - Otherwise latch byte into the shift register, clear the baud counter, go to START.
  - START: tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, LSB first. Shift right after each bit. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then if byte_idx==3 go to IDLE, else byte_idx++ and go to LOAD.
- tx is registered; there are no glitches between states.
- Latency, FIFO empty and FSM idle:
  - print_en sampled at edge N.
  - Word is in the FIFO after N, popped at N+1, LOAD at N+2.
  - tx falls after edge N+3, i.e. 3 cycles after the strobe.
- Per transmitted byte: 1 LOAD cycle + 10·CLKS_PER_BIT cycles. Each skipped byte costs 1 LOAD cycle.
- A word of all zeros with SKIP_ZERO=1 produces no tx activity and returns to IDLE after 4 LOAD cycles.
- busy = (state!=IDLE) | (fifo_count!=0).
- Back-to-back words: after the STOP of byte 3, IDLE pops the next word on the next cycle, with no extra idle bit beyond the stop bit.
- Pointers wrap modulo FIFO_DEPTH. fifo_count never exceeds FIFO_DEPTH.

Test Plan:
- Reset:
  - Setup: CLK_FREQ=8, BAUD_RATE=1 (CLKS_PER_BIT=8). Hold start=0 for 3 cycles.
  - Required response: tx=1, busy=0, overflow=0, fifo_count=0.
- Single word:
  - Stimulus: print_data=0x0000_0A41, SKIP_ZERO=1.
  - Required response: tx low 3 cycles after the strobe. Bytes 0x41 then 0x0A, each 80 cycles LSB-first 8N1. Bytes 2 and 3 skipped. busy falls 2 LOAD cycles after the 2nd stop bit ends.
- Full word:
  - Stimulus: SKIP_ZERO=0, print_data=0x0000_0000.
  - Required response: four 0x00 frames. Total 4·81=324 cycles from first LOAD to return to IDLE.
- Overflow:
  - Stimulus: FIFO_DEPTH=4. Issue 6 strobes on consecutive cycles while the first word is transmitting (word 1 popped, words 2–5 fill the FIFO, word 6 dropped).
  - Required response: overflow=1 from the 6th strobe's edge. Exactly 5 words emitted, in order.
- Reset mid-frame:
  - Stimulus: drop start during DATA bit 3.
  - Required response: tx=1 next cycle, fifo_count=0. A new strobe after start=1 transmits cleanly.
- Push/pop coincidence:
  - Stimulus: fifo_count=1 in IDLE, strobe in the same cycle as the pop.
  - Required response: fifo_count stays 1, both words transmitted in order.
